// File: rtl/multi_ch_tsic_ctrl_if.sv
// Bus bundle between the TSIC controller, serial_comm and the channel-muxed PTAT A2D.
// The master side is the host/A2D environment; the slave side is the controller.
interface multi_ch_tsic_ctrl_if #(
  parameter int A2D_W = 12
);
  logic             cmd_rdy;
  logic [15:0]      cmd;
  logic             trmt;
  logic [15:0]      tx_data;
  logic             strt;
  logic [1:0]       a2d_ch;
  logic             cmplt;
  logic [A2D_W-1:0] a2d;
  logic             busy;
  logic             cmd_drop;

  modport master (
    output cmd_rdy, cmd, cmplt, a2d,
    input  trmt, tx_data, strt, a2d_ch, busy, cmd_drop
  );

  modport slave (
    input  cmd_rdy, cmd, cmplt, a2d,
    output trmt, tx_data, strt, a2d_ch, busy, cmd_drop
  );
endinterface

// File: rtl/multi_ch_tsic_ctrl.sv
// Multi-channel temperature-sensor controller: command decode, oversampled A2D conversion,
// per-channel gain/offset calibration with saturation, conversion timeout.
module multi_ch_tsic_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int A2D_W    = 12,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 4095
) (
    input logic                 clk,
    input logic                 rst,
    multi_ch_tsic_ctrl_if.slave bus
);
    localparam int ACC_W  = A2D_W + AVG_LOG2;
    localparam int PROD_W = A2D_W + 12;
    localparam int SUM_W  = A2D_W + 6;
    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam logic [4:0] LAST_SMP = 5'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {IDLE, STRT, WAIT, MUL, SAT, XMIT} state_t;
    typedef enum logic [1:0] {OP_WR_OFF, OP_WR_GAIN, OP_CONV, OP_RD_LAST} op_t;

    typedef struct packed {
        op_t        op;
        logic [1:0] ch;
        logic [11:0] data;
    } cmd_t;

    state_t              state, state_n;
    cmd_t                cmd;
    logic                ch_ok;
    logic                ld_tx;
    logic [15:0]         tx_n, tx_q;
    logic                cmd_drop_q;
    logic [1:0]          ch_q;
    logic [4:0]          cnt;
    logic [TMR_W-1:0]    timer;
    logic [ACC_W-1:0]    acc;
    logic [PROD_W-1:0]   prod_q;
    logic [11:0]         gain     [4];
    logic [11:0]         offset   [4];
    logic [11:0]         last_res [4];
    logic signed [SUM_W-1:0] sum;
    logic [A2D_W-1:0]    clamped;
    logic [11:0]         res;

    assign cmd   = cmd_t'(bus.cmd);
    assign ch_ok = 32'(cmd.ch) < NUM_CH;

    // Calibration: drop the 8 fractional gain bits, add signed offset, saturate to A2D range.
    always_comb begin
        sum = $signed({2'b00, prod_q[PROD_W-1:8]})
            + $signed({{(SUM_W-12){offset[ch_q][11]}}, offset[ch_q]});
        if (sum[SUM_W-1])
            clamped = '0;
        else if (|sum[SUM_W-2:A2D_W])
            clamped = '1;
        else
            clamped = sum[A2D_W-1:0];
        res = 12'(clamped);
    end

    always_comb begin
        state_n = state;
        ld_tx   = 1'b0;
        tx_n    = tx_q;
        unique case (state)
            IDLE: if (bus.cmd_rdy) begin
                if (cmd.op == OP_CONV || cmd.op == OP_RD_LAST) begin
                    if (!ch_ok) begin
                        state_n = XMIT;
                        ld_tx   = 1'b1;
                        tx_n    = {1'b1, 1'b0, cmd.ch, 12'hFFF};
                    end else if (cmd.op == OP_CONV) begin
                        state_n = STRT;
                    end else begin
                        state_n = XMIT;
                        ld_tx   = 1'b1;
                        tx_n    = {1'b0, 1'b0, cmd.ch, last_res[cmd.ch]};
                    end
                end
            end
            STRT: state_n = WAIT;
            // A cmplt landing on the timeout cycle is still accepted.
            WAIT: if (bus.cmplt) begin
                state_n = (cnt == LAST_SMP) ? MUL : STRT;
            end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                state_n = XMIT;
                ld_tx   = 1'b1;
                tx_n    = {1'b1, 1'b0, ch_q, 12'hFFF};
            end
            MUL: state_n = SAT;
            SAT: begin
                state_n = XMIT;
                ld_tx   = 1'b1;
                tx_n    = {1'b0, 1'b0, ch_q, res};
            end
            XMIT: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx_q       <= '0;
            cmd_drop_q <= 1'b0;
            ch_q       <= '0;
            cnt        <= '0;
            timer      <= '0;
            acc        <= '0;
            prod_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                gain[i]     <= 12'h100;
                offset[i]   <= '0;
                last_res[i] <= '0;
            end
        end else begin
            state      <= state_n;
            cmd_drop_q <= bus.cmd_rdy && (state != IDLE);
            if (ld_tx) tx_q <= tx_n;
            if (state == IDLE && bus.cmd_rdy && ch_ok) begin
                if (cmd.op == OP_WR_OFF)  offset[cmd.ch] <= cmd.data;
                if (cmd.op == OP_WR_GAIN) gain[cmd.ch]   <= cmd.data;
                if (cmd.op == OP_CONV) begin
                    ch_q <= cmd.ch;
                    cnt  <= '0;
                    acc  <= '0;
                end
            end
            // timer counts cycles since the strt pulse
            if (state == STRT) timer <= TMR_W'(1);
            else if (state == WAIT) timer <= timer + 1'b1;
            if (state == WAIT && bus.cmplt) begin
                acc <= acc + ACC_W'(bus.a2d);
                cnt <= cnt + 1'b1;
            end
            if (state == MUL)
                prod_q <= PROD_W'(acc[ACC_W-1:AVG_LOG2]) * PROD_W'(gain[ch_q]);
            // RD_LAST rewrites the same value; error results never reach last_res.
            if (state == XMIT && !tx_q[15])
                last_res[tx_q[13:12]] <= tx_q[11:0];
        end
    end

    assign bus.trmt     = (state == XMIT);
    assign bus.strt     = (state == STRT);
    assign bus.busy     = (state != IDLE);
    assign bus.tx_data  = tx_q;
    assign bus.a2d_ch   = ch_q;
    assign bus.cmd_drop = cmd_drop_q;
endmodule

// File: tb/tb_multi_ch_tsic_ctrl.sv
// Directed bench for multi_ch_tsic_ctrl with NUM_CH=3, a short TIMEOUT and 4x averaging.
module tb_multi_ch_tsic_ctrl;
    localparam int NUM_CH  = 3;
    localparam int TIMEOUT = 40;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   strt_cnt = 0;

    multi_ch_tsic_ctrl_if #(.A2D_W(12)) bus ();

    multi_ch_tsic_ctrl #(
        .NUM_CH(NUM_CH), .A2D_W(12), .AVG_LOG2(2), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.strt) strt_cnt <= strt_cnt + 1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle C+1.
    task automatic send_cmd(input logic [1:0] op, input logic [1:0] ch, input logic [11:0] data);
        bus.cmd     = {op, ch, data};
        bus.cmd_rdy = 1'b1;
        tick();
        bus.cmd_rdy = 1'b0;
    endtask

    task automatic conv(input string tag, input logic [1:0] ch,
                        input logic [11:0] a0, input logic [11:0] a1,
                        input logic [11:0] a2, input logic [11:0] a3,
                        input logic [15:0] exp);
        logic [11:0] smp [4];
        int s0;
        smp = '{a0, a1, a2, a3};
        s0  = strt_cnt;
        send_cmd(2'b10, ch, 12'h000);
        chk({tag, "_a2d_ch"}, 16'(bus.a2d_ch), 16'(ch));
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_strt"}, 16'(bus.strt), 16'h1);
            tick();
            bus.a2d   = smp[i];
            bus.cmplt = 1'b1;
            tick();
            bus.cmplt = 1'b0;
        end
        tick();
        chk({tag, "_trmt_early"}, 16'(bus.trmt), 16'h0);
        tick();
        chk({tag, "_trmt"}, 16'(bus.trmt), 16'h1);
        chk({tag, "_tx"}, bus.tx_data, exp);
        chk({tag, "_nstrt"}, 16'(strt_cnt - s0), 16'd4);
        tick();
        chk({tag, "_busy_off"}, 16'(bus.busy), 16'h0);
        chk({tag, "_tx_hold"}, bus.tx_data, exp);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_trmt"}, 16'(bus.trmt), 16'h0);
        chk({tag, "_strt"}, 16'(bus.strt), 16'h0);
        chk({tag, "_busy"}, 16'(bus.busy), 16'h0);
        chk({tag, "_drop"}, 16'(bus.cmd_drop), 16'h0);
        chk({tag, "_tx"}, bus.tx_data, 16'h0000);
        chk({tag, "_ch"}, 16'(bus.a2d_ch), 16'h0);
    endtask

    initial begin
        int  n;
        int  s0;
        logic drop_seen;

        rst = 1'b1;
        bus.cmd_rdy = 1'b0;
        bus.cmd     = '0;
        bus.cmplt   = 1'b0;
        bus.a2d     = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk_reset_outs("rst");

        // Reset contents and the out-of-range channel path
        send_cmd(2'b11, 2'd2, 12'h000);
        chk("rdlast2_trmt", 16'(bus.trmt), 16'h1);
        chk("rdlast2_tx", bus.tx_data, 16'h2000);
        tick();
        chk("rdlast2_trmt_off", 16'(bus.trmt), 16'h0);
        send_cmd(2'b10, 2'd3, 12'h000);
        chk("badch_trmt", 16'(bus.trmt), 16'h1);
        chk("badch_tx", bus.tx_data, 16'hBFFF);
        chk("badch_nostrt", 16'(bus.strt), 16'h0);
        tick();

        conv("conv0", 2'd0, 12'd100, 12'd102, 12'd104, 12'd106, 16'h0067);

        // (103*2) - 5 = 201
        send_cmd(2'b01, 2'd1, 12'h200);
        send_cmd(2'b00, 2'd1, 12'hFFB);
        conv("conv1", 2'd1, 12'd102, 12'd103, 12'd104, 12'd103, 16'h10C9);
        send_cmd(2'b11, 2'd1, 12'h000);
        chk("rdlast1_tx", bus.tx_data, 16'h10C9);
        tick();

        // Saturation at both ends: 4000*2 overflows, 90*2-200 underflows
        send_cmd(2'b01, 2'd2, 12'h200);
        conv("clamp_hi", 2'd2, 12'd4000, 12'd4000, 12'd4000, 12'd4000, 16'h2FFF);
        send_cmd(2'b00, 2'd2, 12'hF38);
        conv("clamp_lo", 2'd2, 12'd90, 12'd90, 12'd90, 12'd90, 16'h2000);

        // Timeout with cmplt withheld; a cmd arrives while busy
        s0 = strt_cnt;
        send_cmd(2'b10, 2'd1, 12'h000);
        chk("to_strt", 16'(bus.strt), 16'h1);
        drop_seen = 1'b0;
        n = 0;
        for (int i = 1; i <= TIMEOUT + 5; i++) begin
            bus.cmd     = {2'b11, 2'd0, 12'h000};
            bus.cmd_rdy = (i == 5);
            tick();
            bus.cmd_rdy = 1'b0;
            if (i == 5) drop_seen = bus.cmd_drop;
            if (bus.trmt) begin
                n = i;
                break;
            end
        end
        chk("to_latency", 16'(n), 16'(TIMEOUT));
        chk("to_tx", bus.tx_data, 16'h9FFF);
        chk("to_drop", 16'(drop_seen), 16'h1);
        chk("to_nstrt", 16'(strt_cnt - s0), 16'd1);
        tick();
        send_cmd(2'b11, 2'd1, 12'h000);
        chk("to_lastres_kept", bus.tx_data, 16'h10C9);
        tick();

        // Reset in WAIT aborts without trmt and restores calibration
        send_cmd(2'b10, 2'd2, 12'h000);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outs("midrst");
        bus.a2d   = 12'd500;
        bus.cmplt = 1'b1;
        tick();
        bus.cmplt = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.trmt || bus.strt) n++;
            tick();
        end
        chk("midrst_quiet", 16'(n), 16'h0);
        send_cmd(2'b11, 2'd0, 12'h000);
        chk("midrst_lastres0", bus.tx_data, 16'h0000);
        tick();
        conv("post_rst", 2'd1, 12'd103, 12'd103, 12'd103, 12'd103, 16'h1067);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, observed timeout expected completion");
        $fatal(1);
    end
endmodule
